conc_bytes_sched: RTL and testbench
===================================

// Module: conc_bytes_sched
// PURPOSE
//  MCU-order scheduler sharing one conc_bytes packer between N_REQ Huffman code-word sources (Y, Cb, Cr).
//  Grants one source at a time in the order: MCU, then component, then block. Forwards its code words, one per cycle.
//  Drives in_eoi with the final code word of the image, then holds off until the packer's EOI flush completes.
//  Sits between the per-component entropy coders and conc_bytes.
// PARAMETERS
//  N_REQ   3   number of code-word sources, served in index order 0..N_REQ-1 within each MCU
//  MCU_W   16  width of MCU counter / cfg_mcu_num
// PORTS
//  clk          in   1          clock
//  nrst         in   1          asynchronous active-low reset
//  start        in   1          1-cycle pulse: sample cfg_*, begin image
//  abort        in   1          synchronous abort, return to IDLE
//  cfg_mcu_num  in   MCU_W      MCUs in image (0 = invalid)
//  cfg_blk      in   N_REQ*3    blocks per MCU for each source, [3i+2:3i] (0 = skip source)
//  req_len      in   N_REQ*6    code length 0..24, [6i+5:6i]
//  req_bin      in   N_REQ*24   code word, right aligned, [24i+23:24i]
//  req_valid    in   N_REQ      code word present
//  req_last     in   N_REQ      code word is last of its 8x8 block (EOB)
//  req_ready    out  N_REQ      one-hot grant; accept = req_valid[i] & req_ready[i]
//  out_len      out  6          to conc_bytes.in_len
//  out_bin      out  24         to conc_bytes.in_bin
//  out_valid    out  1          to conc_bytes.in_valid
//  out_eoi      out  1          to conc_bytes.in_eoi
//  busy         out  1          state != IDLE
//  done         out  1          1-cycle pulse, image fully flushed
//  bit_cnt      out  32         total accepted code bits (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; state IDLE; counters 0.
//  States:
//   IDLE: on start with cfg_mcu_num != 0 and any cfg_blk != 0, latch cfg.
//     Select the lowest source i with cfg_blk[i] != 0; blk = 0, mcu = 0; go to RUN.
//     Otherwise start is ignored.
//   RUN: req_ready = onehot(cur) only here. Otherwise req_ready = 0.
//   EOI_WAIT: 3-cycle count. out_valid = 0 throughout.
//     This covers the packer's 3-cycle flush, during which new input corrupts its output.
//     Then pulse done and go to IDLE.
//  Datapath latency: 1 cycle, registered.
//   On accept, next cycle: out_valid = 1, out_len/out_bin = req_len/req_bin of cur.
//   No accept: out_valid = 0, out_len/out_bin hold.
//  len 0 words are forwarded unchanged. len > 24 is out of contract.
//  Sequencing on accept with req_last:
//   blk < cfg_blk[cur]-1: blk++.
//   Else blk = 0; cur = next source with cfg_blk != 0.
//     Wrapping past N_REQ-1 starts the next MCU: mcu++.
//   Final code word: last block of last source of MCU cfg_mcu_num-1.
//     out_eoi = 1 alongside its out_valid. State goes to EOI_WAIT.
//     mcu wraps cfg_mcu_num-1 -> 0 and does not overflow.
//  Grant handover is 0-cycle: the new source may be accepted the cycle after the previous source's last word.
//  Within one source, back-to-back accepts every cycle are allowed.
//  Simultaneous events:
//   abort has priority over everything. Next cycle: state IDLE, req_ready = 0, out_valid = 0, out_eoi = 0, no done.
//   start while busy is ignored.
//   start with abort: abort wins.
//  Async reset mid-image returns to IDLE immediately. No EOI is emitted.
// CONFIGURATION
//  CONC_SCHED_BITCNT_EN defined:
//   bit_cnt accumulates req_len on every accept, 32-bit wrap.
//   Cleared on accepted start and on reset. abort does not clear it.
//   Count excludes the 1s padding the packer appends.
//  Not defined: bit_cnt tied to 0; no counter logic.
// TESTING
//  T1 cfg_mcu_num=1, cfg_blk={1,1,1}; each source sends 2 words, 2nd with last.
//     -> 6 out_valid in order Y,Cb,Cr. out_eoi only on the 6th word. done 4 cycles after it.
//  T2 4:2:0: cfg_blk={1,1,4}, cfg_mcu_num=2.
//     -> grant order Y,Y,Y,Y,Cb,Cr twice. req_ready never asserted for an idle source.
//  T3 cfg_blk={1,0,1} -> source 1 never granted. Image completes with 2 blocks per MCU.
//  T4 abort asserted mid-RUN together with an accept.
//     -> no out_valid next cycle, busy=0, no done. A restart then begins at mcu=0, Y.
//  T5 start with cfg_mcu_num=0 -> stays IDLE, busy=0.
//     start pulsed during EOI_WAIT -> ignored.
//  T6 (CONC_SCHED_BITCNT_EN) T1 with lengths {4,4,2,4,3,4} -> bit_cnt=21 after done.

Source files
------------

// File: rtl/conc_bytes_sched.sv
// rtl/conc_bytes_sched.sv - MCU-order scheduler sharing one conc_bytes packer between N_REQ code-word sources
// Optional feature macro: CONC_SCHED_BITCNT_EN (accepted-bit counter on bit_cnt).
module conc_bytes_sched #(
    parameter int N_REQ = 3,
    parameter int MCU_W = 16
) (
    input  logic                clk,
    input  logic                nrst,
    input  logic                start,
    input  logic                abort,
    input  logic [MCU_W-1:0]    cfg_mcu_num,
    input  logic [N_REQ*3-1:0]  cfg_blk,
    input  logic [N_REQ*6-1:0]  req_len,
    input  logic [N_REQ*24-1:0] req_bin,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ-1:0]    req_last,
    output logic [N_REQ-1:0]    req_ready,
    output logic [5:0]          out_len,
    output logic [23:0]         out_bin,
    output logic                out_valid,
    output logic                out_eoi,
    output logic                busy,
    output logic                done,
    output logic [31:0]         bit_cnt
);
    localparam int CW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_EOI_WAIT} state_t;

    state_t             state, state_nx;
    logic [CW-1:0]      cur, cur_nx;
    logic [2:0]         blk, blk_nx;
    logic [MCU_W-1:0]   mcu, mcu_nx, mcu_num;
    logic [N_REQ*3-1:0] blk_cfg;
    logic [1:0]         cnt, cnt_nx;

    logic               sel_valid, sel_last;
    logic [5:0]         sel_len;
    logic [23:0]        sel_bin;
    logic [2:0]         cur_blk;
    logic               nxt_found, first_found, start_found;
    logic [CW-1:0]      nxt_idx, first_idx, start_idx;
    logic               accept, latch, fin, done_nx;

    // Mux the granted source and find the next/first enabled sources.
    always_comb begin
        sel_valid   = 1'b0;
        sel_last    = 1'b0;
        sel_len     = '0;
        sel_bin     = '0;
        cur_blk     = '0;
        nxt_found   = 1'b0;
        nxt_idx     = '0;
        first_found = 1'b0;
        first_idx   = '0;
        start_found = 1'b0;
        start_idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (cur == CW'(i)) begin
                sel_valid = req_valid[i];
                sel_last  = req_last[i];
                sel_len   = req_len[6*i +: 6];
                sel_bin   = req_bin[24*i +: 24];
                cur_blk   = blk_cfg[3*i +: 3];
            end
            if (blk_cfg[3*i +: 3] != 3'd0) begin
                if (!first_found) begin
                    first_found = 1'b1;
                    first_idx   = CW'(i);
                end
                if (!nxt_found && i > int'(cur)) begin
                    nxt_found = 1'b1;
                    nxt_idx   = CW'(i);
                end
            end
            if (!start_found && cfg_blk[3*i +: 3] != 3'd0) begin
                start_found = 1'b1;
                start_idx   = CW'(i);
            end
        end
    end

    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            req_ready[i] = (state == S_RUN) && (cur == CW'(i));
        end
    end

    assign accept = (state == S_RUN) && sel_valid;

    always_comb begin
        state_nx = state;
        cur_nx   = cur;
        blk_nx   = blk;
        mcu_nx   = mcu;
        cnt_nx   = cnt;
        latch    = 1'b0;
        fin      = 1'b0;
        done_nx  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start && cfg_mcu_num != '0 && start_found) begin
                    state_nx = S_RUN;
                    cur_nx   = start_idx;
                    blk_nx   = 3'd0;
                    mcu_nx   = '0;
                    latch    = 1'b1;
                end
            end
            S_RUN: begin
                if (accept && sel_last) begin
                    if (({1'b0, blk} + 4'd1) < {1'b0, cur_blk}) begin
                        blk_nx = blk + 3'd1;
                    end else begin
                        blk_nx = 3'd0;
                        if (nxt_found) begin
                            cur_nx = nxt_idx;
                        end else begin
                            cur_nx = first_idx;
                            if (mcu == mcu_num - MCU_W'(1)) begin
                                mcu_nx   = '0;
                                fin      = 1'b1;
                                cnt_nx   = 2'd0;
                                state_nx = S_EOI_WAIT;
                            end else begin
                                mcu_nx = mcu + MCU_W'(1);
                            end
                        end
                    end
                end
            end
            S_EOI_WAIT: begin
                // The word carrying in_eoi is followed by the packer's 3-cycle flush.
                if (cnt == 2'd3) begin
                    state_nx = S_IDLE;
                    done_nx  = 1'b1;
                end else begin
                    cnt_nx = cnt + 2'd1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
        if (abort) begin
            state_nx = S_IDLE;
            latch    = 1'b0;
            fin      = 1'b0;
            done_nx  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            cur       <= '0;
            blk       <= '0;
            mcu       <= '0;
            cnt       <= '0;
            mcu_num   <= '0;
            blk_cfg   <= '0;
            out_len   <= '0;
            out_bin   <= '0;
            out_valid <= 1'b0;
            out_eoi   <= 1'b0;
            done      <= 1'b0;
        end else begin
            cur       <= cur_nx;
            blk       <= blk_nx;
            mcu       <= mcu_nx;
            cnt       <= cnt_nx;
            out_valid <= accept && !abort;
            out_eoi   <= fin;
            done      <= done_nx;
            if (latch) begin
                mcu_num <= cfg_mcu_num;
                blk_cfg <= cfg_blk;
            end
            if (accept && !abort) begin
                out_len <= sel_len;
                out_bin <= sel_bin;
            end
        end
    end

    assign busy = (state != S_IDLE);

`ifdef CONC_SCHED_BITCNT_EN
    logic [31:0] bit_acc;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            bit_acc <= '0;
        end else if (latch) begin
            bit_acc <= '0;
        end else if (accept && !abort) begin
            bit_acc <= bit_acc + {26'd0, sel_len};
        end
    end

    assign bit_cnt = bit_acc;
`else
    assign bit_cnt = '0;
`endif

endmodule

// File: tb/tb_conc_bytes_sched.sv
// tb/tb_conc_bytes_sched.sv - self-checking bench for conc_bytes_sched
module tb_conc_bytes_sched;
    logic        clk = 1'b0;
    logic        nrst;
    logic        start;
    logic        abort;
    logic [15:0] cfg_mcu_num;
    logic [8:0]  cfg_blk;
    logic [17:0] req_len;
    logic [71:0] req_bin;
    logic [2:0]  req_valid;
    logic [2:0]  req_last;
    logic [2:0]  req_ready;
    logic [5:0]  out_len;
    logic [23:0] out_bin;
    logic        out_valid;
    logic        out_eoi;
    logic        busy;
    logic        done;
    logic [31:0] bit_cnt;

    always #5 clk = ~clk;

    conc_bytes_sched #(.N_REQ(3), .MCU_W(16)) dut (
        .clk(clk), .nrst(nrst), .start(start), .abort(abort),
        .cfg_mcu_num(cfg_mcu_num), .cfg_blk(cfg_blk),
        .req_len(req_len), .req_bin(req_bin), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready), .out_len(out_len), .out_bin(out_bin), .out_valid(out_valid),
        .out_eoi(out_eoi), .busy(busy), .done(done), .bit_cnt(bit_cnt)
    );

    typedef struct packed {
        logic [1:0]  src;
        logic        last;
        logic [5:0]  len;
        logic [23:0] bin;
    } word_t;

    typedef struct {
        logic [15:0] mcu;
        logic [8:0]  blk;
        int          words;
        int          exp_out;
    } vec_t;

    word_t src_q[3][$];
    word_t exp_q[$];
    int    vecs = 0;
    int    errs = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vecs++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic clear_queues();
        for (int i = 0; i < 3; i++) src_q[i].delete();
        exp_q.delete();
    endtask

    // Reference order: every MCU, every source in index order, every block, its words.
    task automatic gen_image(input int mcu, input logic [8:0] blk, input int words);
        word_t w;
        int nw;
        clear_queues();
        for (int m = 0; m < mcu; m++)
            for (int i = 0; i < 3; i++)
                for (int b = 0; b < int'(blk[3*i +: 3]); b++) begin
                    nw = (words > 0) ? words : int'($urandom_range(1, 3));
                    for (int k = 0; k < nw; k++) begin
                        w.src  = 2'(i);
                        w.last = (k == nw - 1);
                        w.len  = 6'($urandom_range(0, 24));
                        w.bin  = 24'($urandom) & ~(24'hFFFFFF << w.len);
                        src_q[i].push_back(w);
                        exp_q.push_back(w);
                    end
                end
    endtask

    // Disabled sources always offer garbage so an illegal grant is visible.
    task automatic drive_sources(input logic [8:0] blk, input int vprob);
        word_t w;
        for (int i = 0; i < 3; i++) begin
            if (blk[3*i +: 3] == 3'd0) begin
                req_valid[i]         = 1'b1;
                req_last[i]          = 1'b1;
                req_len[6*i +: 6]    = 6'd24;
                req_bin[24*i +: 24]  = 24'hBADBAD;
            end else if (src_q[i].size() > 0 && int'($urandom_range(0, 99)) < vprob) begin
                w = src_q[i][0];
                req_valid[i]         = 1'b1;
                req_last[i]          = w.last;
                req_len[6*i +: 6]    = w.len;
                req_bin[24*i +: 24]  = w.bin;
            end else begin
                req_valid[i]         = 1'b0;
                req_last[i]          = 1'b0;
                req_len[6*i +: 6]    = 6'd0;
                req_bin[24*i +: 24]  = 24'd0;
            end
        end
    endtask

    task automatic run_image(input int mcu, input logic [8:0] blk, input int vprob,
                             input bit poke, output int n_out);
        int out_idx = 0;
        int acc_idx = 0;
        int cyc = 0;
        int eoi_cyc = -100;
        int sum = 0;
        bit got_done = 0;
        bit poked = 0;
        logic [2:0] acc;
        foreach (exp_q[k]) sum += int'(exp_q[k].len);
        @(posedge clk); #1;
        cfg_mcu_num = 16'(mcu);
        cfg_blk     = blk;
        start       = 1'b1;
        drive_sources(blk, vprob);
        @(posedge clk); #1;
        start = 1'b0;
        drive_sources(blk, vprob);
        while (!got_done && cyc < 3000) begin
            @(negedge clk);
            if (out_valid) begin
                if (out_idx < exp_q.size()) begin
                    check("out_len", out_len, exp_q[out_idx].len);
                    check("out_bin", out_bin, exp_q[out_idx].bin);
                    check("out_eoi", out_eoi, out_idx == exp_q.size() - 1);
                end else begin
                    check("extra_word", out_valid, 0);
                end
                if (out_eoi) eoi_cyc = cyc;
                out_idx++;
            end else if (out_eoi) begin
                check("eoi_without_valid", out_eoi, 0);
            end
            if (req_ready != 3'd0) begin
                if (acc_idx < exp_q.size())
                    check("grant", req_ready, 3'b001 << exp_q[acc_idx].src);
                else
                    check("grant_after_end", req_ready, 0);
            end
            if (done) begin
                got_done = 1;
                check("done_delay", cyc - eoi_cyc, 4);
                check("word_count", out_idx, exp_q.size());
                check("busy_at_done", busy, 0);
`ifdef CONC_SCHED_BITCNT_EN
                check("bit_cnt", bit_cnt, sum);
`else
                check("bit_cnt_tied", bit_cnt, 0);
`endif
            end
            acc = req_valid & req_ready;
            @(posedge clk); #1;
            for (int i = 0; i < 3; i++) begin
                if (acc[i] && src_q[i].size() > 0) begin
                    void'(src_q[i].pop_front());
                    acc_idx++;
                end
            end
            start = poke && (eoi_cyc >= 0) && !poked;
            if (start) poked = 1;
            drive_sources(blk, vprob);
            cyc++;
        end
        check("done_seen", got_done, 1);
        start     = 1'b0;
        req_valid = 3'd0;
        if (poke) begin
            repeat (3) begin
                @(negedge clk);
                check("start_in_eoi_ignored", busy, 0);
            end
        end
        n_out = out_idx;
    endtask

    vec_t tbl[7];
    int   n;
    logic [8:0] rb;
    int   rm;
    bit   seen_done;

    initial begin
        tbl[0] = '{16'd1, {3'd1, 3'd1, 3'd1}, 2, 6};
        tbl[1] = '{16'd2, {3'd1, 3'd1, 3'd4}, 1, 12};
        tbl[2] = '{16'd3, {3'd1, 3'd0, 3'd1}, 1, 6};
        tbl[3] = '{16'd1, {3'd7, 3'd7, 3'd7}, 1, 21};
        tbl[4] = '{16'd0, {3'd1, 3'd1, 3'd1}, 1, 0};
        tbl[5] = '{16'd5, {3'd0, 3'd0, 3'd0}, 1, 0};
        tbl[6] = '{16'd2, {3'd2, 3'd3, 3'd0}, 2, 20};

        nrst = 1'b0; start = 1'b0; abort = 1'b0;
        cfg_mcu_num = '0; cfg_blk = '0;
        req_len = '0; req_bin = '0; req_valid = '0; req_last = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", {req_ready, out_len, out_bin, out_valid, out_eoi, busy, done}, 0);
        check("reset_bit_cnt", bit_cnt, 0);
        @(posedge clk); #1;
        nrst = 1'b1;

        for (int t = 0; t < 7; t++) begin
            if (tbl[t].exp_out == 0) begin
                @(posedge clk); #1;
                cfg_mcu_num = tbl[t].mcu;
                cfg_blk     = tbl[t].blk;
                start       = 1'b1;
                @(posedge clk); #1;
                start = 1'b0;
                @(negedge clk);
                check("start_ignored", {busy, out_valid, req_ready}, 0);
            end else begin
                gen_image(int'(tbl[t].mcu), tbl[t].blk, tbl[t].words);
                run_image(int'(tbl[t].mcu), tbl[t].blk, 100, 0, n);
                check("table_words", n, tbl[t].exp_out);
            end
        end

        // start and abort together in IDLE: abort wins
        @(posedge clk); #1;
        cfg_mcu_num = 16'd1; cfg_blk = 9'o111; start = 1'b1; abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        @(negedge clk);
        check("start_with_abort", busy, 0);

        // abort together with an accept mid-RUN
        @(posedge clk); #1;
        cfg_mcu_num = 16'd2; cfg_blk = 9'o111; start = 1'b1;
        req_valid = 3'b111; req_last = 3'b000; req_len = {3{6'd5}}; req_bin = {3{24'h1F}};
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check("pre_abort_grant", req_ready, 3'b001);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort_next_cycle", {out_valid, out_eoi, busy, req_ready}, 0);
        seen_done = 0;
        repeat (6) begin
            @(negedge clk);
            seen_done |= done;
        end
        check("abort_no_done", seen_done, 0);
        req_valid = 3'd0;
        gen_image(2, 9'o111, 2);
        run_image(2, 9'o111, 80, 0, n);
        check("restart_words", n, 12);

        // asynchronous reset mid-image
        @(posedge clk); #1;
        cfg_mcu_num = 16'd1; cfg_blk = 9'o111; start = 1'b1;
        req_valid = 3'b111; req_last = 3'b000;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        nrst = 1'b0;
        #1;
        check("async_reset", {busy, out_valid, out_eoi, req_ready}, 0);
        @(posedge clk); #1;
        nrst = 1'b1;
        req_valid = 3'd0;

        for (int r = 0; r < 25; r++) begin
            rm = int'($urandom_range(1, 4));
            rb = 9'($urandom);
            for (int i = 0; i < 3; i++) rb[3*i +: 3] = 3'(rb[3*i +: 3] % 4);
            if (rb == 9'd0) rb[0] = 1'b1;
            gen_image(rm, rb, 0);
            run_image(rm, rb, int'($urandom_range(40, 100)), (r % 5) == 0, n);
        end

`ifdef CONC_SCHED_BITCNT_EN
        begin : t6
            int    l6[6];
            word_t w;
            l6 = '{4, 4, 2, 4, 3, 4};
            clear_queues();
            for (int k = 0; k < 6; k++) begin
                w.src  = 2'(k / 2);
                w.last = (k % 2) == 1;
                w.len  = 6'(l6[k]);
                w.bin  = 24'(k);
                src_q[k / 2].push_back(w);
                exp_q.push_back(w);
            end
            run_image(1, 9'o111, 100, 0, n);
            check("t6_bit_cnt", bit_cnt, 21);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
